bcd_to_binary_seq: RTL and testbench

BCD_TO_BINARY_SEQ -- requirements
Module: bcd_to_binary_seq

---
 rtl/bcd_to_binary_seq_if.sv | 34 +++
 rtl/bcd_to_binary_seq.sv | 121 ++++++++++++
 tb/tb_bcd_to_binary_seq.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_to_binary_seq_if.sv
// Handshake and data bundle for the sequential BCD-to-binary converter.
// The master drives the request and the eleven decimal digits; the slave
// returns the binary result and status.
interface bcd_to_binary_seq_if;
   logic        start;
   logic [3:0]  BCD0;
   logic [3:0]  BCD1;
   logic [3:0]  BCD2;
   logic [3:0]  BCD3;
   logic [3:0]  BCD4;
   logic [3:0]  BCD5;
   logic [3:0]  BCD6;
   logic [3:0]  BCD7;
   logic [3:0]  BCD8;
   logic [3:0]  BCD9;
   logic [3:0]  BCD10;
   logic [35:0] data;
   logic        busy;
   logic        done;
   logic        overflow;
   logic        err_digit;

   modport master (
      output start, BCD0, BCD1, BCD2, BCD3, BCD4, BCD5,
             BCD6, BCD7, BCD8, BCD9, BCD10,
      input  data, busy, done, overflow, err_digit
   );

   modport slave (
      input  start, BCD0, BCD1, BCD2, BCD3, BCD4, BCD5,
             BCD6, BCD7, BCD8, BCD9, BCD10,
      output data, busy, done, overflow, err_digit
   );
endinterface

// File: rtl/bcd_to_binary_seq.sv
// Sequential 11-digit BCD to 36-bit binary converter.
// Digits are captured on start, then folded most-significant first into a
// 37-bit accumulator (acc*10 + digit) over 11 cycles; the result is presented
// with a one-cycle done pulse and held until the next result or reset.
module bcd_to_binary_seq (
   input  logic                    Clk,
   input  logic                    Reset,
   bcd_to_binary_seq_if.slave      bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  idx_q;
   logic [43:0] digits_q;
   logic [36:0] acc_q;
   logic        err_cap_q;
   logic [35:0] data_q;
   logic        overflow_q;
   logic        err_digit_q;

   logic [43:0] digits_in;
   logic        digits_in_bad;
   logic [3:0]  digit_cur;
   logic [36:0] acc_next;
   logic        last_digit;

   assign digits_in = {bus.BCD10, bus.BCD9, bus.BCD8, bus.BCD7, bus.BCD6,
                       bus.BCD5, bus.BCD4, bus.BCD3, bus.BCD2, bus.BCD1,
                       bus.BCD0};

   // Flag any incoming nibble outside 0..9 so the error is known at capture.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      digits_in_bad = 1'b0;
      for (int i = 0; i < 11; i++) begin
         if (digits_in[i*4 +: 4] > 4'd9) digits_in_bad = 1'b1;
      end
   end

   // Shift-and-add multiply by ten, plus the current zero-extended digit.
   assign digit_cur  = digits_q[{idx_q, 2'b00} +: 4];
   assign acc_next   = (acc_q << 3) + (acc_q << 1) + {33'd0, digit_cur};
   assign last_digit = (idx_q == 4'd0);

   // State register.
   always_ff @(posedge Clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (Reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic: start only matters in IDLE; CONVERT ends on digit 0.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = CONVERT;
         CONVERT: if (last_digit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Status outputs decoded directly from the state.
   always_comb begin
      bus.busy = 1'b0;
      bus.done = 1'b0;
      case (state_q)
         CONVERT: bus.busy = 1'b1;
         DONE:    bus.done = 1'b1;
         default: ;
      endcase
   end

   // Datapath: capture, accumulate, and register the result on the last digit.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         idx_q       <= 4'd0;
         digits_q    <= 44'd0;
         acc_q       <= 37'd0;
         err_cap_q   <= 1'b0;
         data_q      <= 36'd0;
         overflow_q  <= 1'b0;
         err_digit_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  digits_q  <= digits_in;
                  acc_q     <= 37'd0;
                  idx_q     <= 4'd10;
                  err_cap_q <= digits_in_bad;
               end
            end
            CONVERT: begin
               acc_q <= acc_next;
               if (last_digit) begin
                  // A bad digit forces a clean zero result but keeps the timing.
                  data_q      <= err_cap_q ? 36'd0 : acc_next[35:0];
                  overflow_q  <= err_cap_q ? 1'b0  : acc_next[36];
                  err_digit_q <= err_cap_q;
               end else begin
                  idx_q <= idx_q - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.data      = data_q;
   assign bus.overflow  = overflow_q;
   assign bus.err_digit = err_digit_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed bench for bcd_to_binary_seq: latency, busy length, results,
// overflow/error flags, reset abort, back-to-back starts and input stability.
module tb_bcd_to_binary_seq;

   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;

   bcd_to_binary_seq_if bus_if ();

   bcd_to_binary_seq dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Digits packed as a hex literal whose nibbles read as the decimal number.
   task automatic set_digits(input logic [43:0] v);
      bus_if.BCD0  = v[3:0];
      bus_if.BCD1  = v[7:4];
      bus_if.BCD2  = v[11:8];
      bus_if.BCD3  = v[15:12];
      bus_if.BCD4  = v[19:16];
      bus_if.BCD5  = v[23:20];
      bus_if.BCD6  = v[27:24];
      bus_if.BCD7  = v[31:28];
      bus_if.BCD8  = v[35:32];
      bus_if.BCD9  = v[39:36];
      bus_if.BCD10 = v[43:40];
   endtask

   // Present digits with start high; returns just after the sampling edge E.
   task automatic launch(input logic [43:0] v);
      @(negedge clk);
      set_digits(v);
      bus_if.start = 1'b1;
      @(posedge clk);
   endtask

   // Count negedges until done (bounded); lat = -1 if done never came.
   task automatic measure(input bit keep_start, output int lat, output int busy_n);
      lat    = -1;
      busy_n = 0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (!keep_start && i == 1) bus_if.start = 1'b0;
         if (bus_if.busy) busy_n++;
         if (bus_if.done) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus_if.start = 1'b0;
      set_digits(44'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if ({bus_if.busy, bus_if.done, bus_if.overflow, bus_if.err_digit} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL reset_flags: got %b expected 0000",
                  {bus_if.busy, bus_if.done, bus_if.overflow, bus_if.err_digit});
      end
      tests_run++;
      if (bus_if.data !== 36'd0) begin
         tests_failed++;
         $display("FAIL reset_data: got %h expected 0", bus_if.data);
      end
      rst = 1'b0;
   endtask

   task automatic test_zero();
      int lat, bn;
      launch(44'h00000000000);
      measure(1'b0, lat, bn);
      tests_run++;
      if (lat !== 12) begin
         tests_failed++;
         $display("FAIL zero_latency: got %0d expected 12", lat);
      end
      tests_run++;
      if (bn !== 11) begin
         tests_failed++;
         $display("FAIL zero_busy_cycles: got %0d expected 11", bn);
      end
      tests_run++;
      if ({bus_if.data, bus_if.overflow, bus_if.err_digit} !== {36'd0, 2'b00}) begin
         tests_failed++;
         $display("FAIL zero_result: got %h/%b/%b expected 0/0/0",
                  bus_if.data, bus_if.overflow, bus_if.err_digit);
      end
      @(negedge clk);
      tests_run++;
      if (bus_if.done !== 1'b0) begin
         tests_failed++;
         $display("FAIL zero_done_width: got %b expected 0", bus_if.done);
      end
   endtask

   task automatic test_max36();
      int lat, bn;
      launch(44'h68719476735);
      measure(1'b0, lat, bn);
      tests_run++;
      if (lat !== 12) begin
         tests_failed++;
         $display("FAIL max36_latency: got %0d expected 12", lat);
      end
      tests_run++;
      if ({bus_if.data, bus_if.overflow, bus_if.err_digit} !== {36'hFFFFFFFFF, 2'b00}) begin
         tests_failed++;
         $display("FAIL max36_result: got %h/%b/%b expected fffffffff/0/0",
                  bus_if.data, bus_if.overflow, bus_if.err_digit);
      end
   endtask

   task automatic test_overflow();
      int lat, bn;
      launch(44'h68719476736);
      measure(1'b0, lat, bn);
      tests_run++;
      if ({bus_if.data, bus_if.overflow, bus_if.err_digit} !== {36'd0, 2'b10}) begin
         tests_failed++;
         $display("FAIL ovf_result: got %h/%b/%b expected 0/1/0",
                  bus_if.data, bus_if.overflow, bus_if.err_digit);
      end
   endtask

   task automatic test_err_digit();
      int lat, bn;
      launch(44'h1111111C111);
      measure(1'b0, lat, bn);
      tests_run++;
      if (lat !== 12) begin
         tests_failed++;
         $display("FAIL err_latency: got %0d expected 12", lat);
      end
      tests_run++;
      if ({bus_if.data, bus_if.overflow, bus_if.err_digit} !== {36'd0, 2'b01}) begin
         tests_failed++;
         $display("FAIL err_result: got %h/%b/%b expected 0/0/1",
                  bus_if.data, bus_if.overflow, bus_if.err_digit);
      end
   endtask

   task automatic test_all_nines();
      int lat, bn;
      launch(44'h99999999999);
      measure(1'b0, lat, bn);
      tests_run++;
      if ({bus_if.data, bus_if.overflow, bus_if.err_digit} !== {36'h74876E7FF, 2'b10}) begin
         tests_failed++;
         $display("FAIL nines_result: got %h/%b/%b expected 74876e7ff/1/0",
                  bus_if.data, bus_if.overflow, bus_if.err_digit);
      end
   endtask

   // Reset at the 5th CONVERT edge aborts; then start in the first free cycle.
   task automatic test_reset_abort();
      int lat, bn;
      int seen_done;
      seen_done = 0;
      launch(44'h11111111111);
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (i == 1) bus_if.start = 1'b0;
         if (bus_if.done) seen_done++;
         if (i == 5) rst = 1'b1;
      end
      @(negedge clk);
      tests_run++;
      if ({bus_if.busy, bus_if.done, bus_if.overflow, bus_if.err_digit} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL abort_flags: got %b expected 0000",
                  {bus_if.busy, bus_if.done, bus_if.overflow, bus_if.err_digit});
      end
      tests_run++;
      if (bus_if.data !== 36'd0) begin
         tests_failed++;
         $display("FAIL abort_data: got %h expected 0", bus_if.data);
      end
      tests_run++;
      if (seen_done !== 0) begin
         tests_failed++;
         $display("FAIL abort_no_done: got %0d expected 0", seen_done);
      end
      rst = 1'b0;
      set_digits(44'h00000000123);
      bus_if.start = 1'b1;
      @(posedge clk);
      measure(1'b0, lat, bn);
      tests_run++;
      if (lat !== 12) begin
         tests_failed++;
         $display("FAIL post_reset_latency: got %0d expected 12", lat);
      end
      tests_run++;
      if (bus_if.data !== 36'd123) begin
         tests_failed++;
         $display("FAIL post_reset_data: got %0d expected 123", bus_if.data);
      end
   endtask

   task automatic test_back_to_back();
      int lat1, lat2, bn1, bn2;
      launch(44'h00000000123);
      measure(1'b1, lat1, bn1);
      measure(1'b1, lat2, bn2);
      bus_if.start = 1'b0;
      tests_run++;
      if (lat1 !== 12) begin
         tests_failed++;
         $display("FAIL b2b_first_latency: got %0d expected 12", lat1);
      end
      tests_run++;
      if (lat2 !== 13) begin
         tests_failed++;
         $display("FAIL b2b_period: got %0d expected 13", lat2);
      end
      tests_run++;
      if (bn2 !== 11) begin
         tests_failed++;
         $display("FAIL b2b_busy_cycles: got %0d expected 11", bn2);
      end
      tests_run++;
      if (bus_if.data !== 36'd123) begin
         tests_failed++;
         $display("FAIL b2b_data: got %0d expected 123", bus_if.data);
      end
      repeat (3) @(negedge clk);
      tests_run++;
      if (bus_if.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_stops: got busy %b expected 0", bus_if.busy);
      end
   endtask

   // Digits change mid-conversion; result and held outputs must not move.
   task automatic test_digit_change();
      int lat, bn;
      launch(44'h00000000456);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (i == 1) bus_if.start = 1'b0;
      end
      set_digits(44'h99999999999);
      tests_run++;
      if (bus_if.data !== 36'd123) begin
         tests_failed++;
         $display("FAIL hold_prev_data: got %0d expected 123", bus_if.data);
      end
      measure(1'b0, lat, bn);
      tests_run++;
      if (lat !== 8) begin
         tests_failed++;
         $display("FAIL change_latency: got %0d expected 8", lat);
      end
      tests_run++;
      if ({bus_if.data, bus_if.overflow, bus_if.err_digit} !== {36'd456, 2'b00}) begin
         tests_failed++;
         $display("FAIL change_result: got %0d/%b/%b expected 456/0/0",
                  bus_if.data, bus_if.overflow, bus_if.err_digit);
      end
      repeat (2) @(negedge clk);
      tests_run++;
      if (bus_if.data !== 36'd456) begin
         tests_failed++;
         $display("FAIL hold_after_done: got %0d expected 456", bus_if.data);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_zero();
      test_max36();
      test_overflow();
      test_err_digit();
      test_all_nines();
      test_reset_abort();
      test_back_to_back();
      test_digit_change();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
